// File: rtl/mp1_mem_responder_pkg.sv
// Shared types for the multicycle-datapath memory responder: FSM states,
// the captured request record and the latency limit.
package mem_resp_types;

    localparam int MEM_RESP_MAX_LATENCY = 15;
    localparam int MEM_RESP_CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        DONE
    } mem_resp_state_t;

    // index carries the full word address so the range check can still see
    // the upper bits after capture.
    typedef struct packed {
        logic        op_write;
        logic [29:0] index;
        logic [3:0]  byte_en;
        logic [31:0] wdata;
        logic        oor;
    } mem_req_t;

    function automatic logic upper_bits_set(input logic [31:0] addr, input int addr_width);
        return (addr >> (addr_width + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/mp1_mem_responder_array.sv
// Byte-enabled word store behind the responder: synchronous write, read port
// follows the index. No reset; contents are undefined until written.
module mem_resp_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            byte_en,
    input  logic [ADDR_WIDTH-1:0] index,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && byte_en[i]) begin
                mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/mp1_mem_responder.sv
// Fixed-latency memory responder for the multicycle RV32I datapath.
// Optional out-of-range detection is enabled by defining MP1_MEM_RANGE_CHECK_EN.
module mp1_mem_responder
    import mem_resp_types::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam logic [MEM_RESP_CNT_W-1:0] LAT_M1 = MEM_RESP_CNT_W'(LATENCY - 1);

    mem_resp_state_t           state_q, state_d;
    logic [MEM_RESP_CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t                  req_q, req_d, live_req, commit_req;
    logic                      commit;
    logic                      arr_we;
    logic [31:0]               arr_rdata;
    logic                      unused_bits;

    always_comb begin
        live_req          = '0;
        live_req.op_write = mem_write;
        live_req.index    = mem_address[31:2];
        live_req.byte_en  = mem_byte_enable;
        live_req.wdata    = mem_wdata;
`ifdef MP1_MEM_RANGE_CHECK_EN
        live_req.oor      = upper_bits_set(mem_address, ADDR_WIDTH);
`else
        live_req.oor      = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    req_d = live_req;
                    if (LATENCY <= 1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= MEM_RESP_CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end
            end
            RESP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the commit edge is also the capture edge, so the live
    // request feeds the array directly from IDLE.
    assign commit     = (state_d == RESP) && (state_q != RESP);
    assign commit_req = (state_q == IDLE) ? live_req : req_q;
    assign arr_we     = commit && commit_req.op_write && !commit_req.oor;

    assign unused_bits = ^{commit_req.index, mem_address[1:0]};

    mem_resp_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .byte_en (commit_req.byte_en),
        .index   (commit_req.index[ADDR_WIDTH-1:0]),
        .wdata   (commit_req.wdata),
        .rdata   (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            mem_resp  <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            mem_resp <= commit;
            if (commit && !commit_req.op_write) begin
                mem_rdata <= commit_req.oor ? 32'h0 : arr_rdata;
            end
        end
    end

`ifdef MP1_MEM_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= commit && commit_req.oor;
        end
    end
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mp1_mem_responder.sv
// Directed bench for mp1_mem_responder: vector table plus hand sequences for
// held requests, address change in WAIT, and resets.
module tb_mp1_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [3:0]  mem_byte_enable = 4'h0;
    logic [31:0] mem_address = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int n_checks = 0;
    int n_errors = 0;

    mp1_mem_responder #(
        .ADDR_WIDTH(10),
        .LATENCY   (LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

`ifdef MP1_MEM_RANGE_CHECK_EN
    localparam logic        E_OOR   = 1'b1;
    localparam logic [31:0] W0_VAL  = 32'h12345678;
    localparam logic [31:0] R_OOR   = 32'h0;
`else
    localparam logic        E_OOR   = 1'b0;
    localparam logic [31:0] W0_VAL  = 32'hCAFEF00D;
    localparam logic [31:0] R_OOR   = 32'hCAFEF00D;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts just after a rising edge; returns at the first IDLE cycle after DONE.
    task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, input bit alt_en, input logic [31:0] alt_a,
                              output int lat, output int pulses,
                              output logic [31:0] rd, output logic er);
        mem_write       = w;
        mem_read        = ~w;
        mem_address     = a;
        mem_wdata       = d;
        mem_byte_enable = be;
        lat    = -1;
        pulses = 0;
        rd     = 32'hx;
        er     = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 && alt_en) mem_address = alt_a;
            if (mem_resp) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    rd  = mem_rdata;
                    er  = mem_err;
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end
            end
            if (lat >= 0 && k >= lat + 2) break;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int          lat, pulses, cnt;
        logic [31:0] rd;
        logic        er;
        int          pos [3];

        vecs[0]  = '{1'b1, 32'h100,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h100,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h100,  32'h000000AA, 4'h1, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 32'h100,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b1, 32'h100,  32'h55000000, 4'h8, 32'hDEADBEAA, 1'b0};
        vecs[5]  = '{1'b0, 32'h100,  32'h0,        4'h0, 32'h55ADBEAA, 1'b0};
        vecs[6]  = '{1'b1, 32'h0,    32'h12345678, 4'hF, 32'h55ADBEAA, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h12345678, 1'b0};
        vecs[8]  = '{1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h12345678, E_OOR};
        vecs[9]  = '{1'b0, 32'h0,    32'h0,        4'h0, W0_VAL,       1'b0};
        vecs[10] = '{1'b0, 32'h1000, 32'h0,        4'h0, R_OOR,        E_OOR};
        vecs[11] = '{1'b1, 32'h200,  32'hA5A5A5A5, 4'hF, R_OOR,        1'b0};
        vecs[12] = '{1'b0, 32'h203,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};

        #2;
        check("reset_resp",  {31'h0, mem_resp}, 32'h0);
        check("reset_rdata", mem_rdata,         32'h0);
        check("reset_err",   {31'h0, mem_err},  32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            run_access(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, 32'h0,
                       lat, pulses, rd, er);
            check($sformatf("v%0d_latency", i), 32'(lat),    32'(LAT));
            check($sformatf("v%0d_pulses", i),  32'(pulses), 32'd1);
            check($sformatf("v%0d_rdata", i),   rd,          vecs[i].exp_rd);
            check($sformatf("v%0d_err", i),     {31'h0, er}, {31'h0, vecs[i].exp_err});
        end

        // Read held high through RESP and DONE: one response per LAT+2 cycles.
        mem_read    = 1'b1;
        mem_address = 32'h100;
        cnt = 0;
        for (int k = 1; k <= 3 * (LAT + 2); k++) begin
            @(posedge clk);
            #1;
            if (mem_resp) begin
                if (cnt < 3) pos[cnt] = k;
                cnt++;
                check($sformatf("held_rdata%0d", cnt), mem_rdata, 32'h55ADBEAA);
            end
        end
        mem_read = 1'b0;
        check("held_count", 32'(cnt), 32'd3);
        if (cnt == 3) begin
            check("held_pos0", 32'(pos[0]), 32'(LAT));
            check("held_pos1", 32'(pos[1]), 32'(2 * LAT + 2));
            check("held_pos2", 32'(pos[2]), 32'(3 * LAT + 4));
        end
        repeat (3) @(posedge clk);
        #1;

        run_access(1'b0, 32'h200, 32'h0, 4'h0, 1'b1, 32'h100, lat, pulses, rd, er);
        check("addr_change_lat",   32'(lat), 32'(LAT));
        check("addr_change_rdata", rd,       32'hA5A5A5A5);

        // Reset while idle with a non-zero read value.
        rst_n = 1'b0;
        #2;
        check("idle_reset_resp",  {31'h0, mem_resp}, 32'h0);
        check("idle_reset_rdata", mem_rdata,         32'h0);
        check("idle_reset_err",   {31'h0, mem_err},  32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write aborted by reset in cycle 1 (before the commit edge).
        mem_write       = 1'b1;
        mem_address     = 32'h200;
        mem_wdata       = 32'h11111111;
        mem_byte_enable = 4'hF;
        @(posedge clk);
        #1 rst_n = 1'b0;
        mem_write = 1'b0;
        #2 rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (mem_resp) cnt++;
        end
        check("abort_no_resp", 32'(cnt), 32'd0);
        run_access(1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0, lat, pulses, rd, er);
        check("abort_lat",   32'(lat), 32'(LAT));
        check("abort_rdata", rd,       32'hA5A5A5A5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
